pipeline_ctrl: RTL and testbench

Sequencer that consumes the hazard unit's stall/flush requests and drives the 4-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates the PC and IF/ID write enables.
- Inserts ID/EX bubbles.
- Tracks a valid bit per stage.
- Handles halt/drain/resume.
- Keeps a stall watchdog.
Sits between hazard_unit and the pipeline register bank in the CPU top.

---
 rtl/pipeline_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Sequencer between the hazard unit and the 4-stage pipeline register bank
// (IF/ID, ID/EX, EX/MEM, MEM/WB). It turns stall/flush requests into PC and
// IF/ID write enables, inserts ID/EX bubbles, tracks one valid bit per
// pipeline register, and handles halt/drain/resume. A watchdog flags stalls
// that persist for too long.
//
// Optional feature macro: PIPELINE_PERF_COUNTERS_EN
//   defined   : stall_cycles / flush_events are saturating event counters
//   undefined : both outputs are tied to zero and no counter flops exist
//
// Parameters
//   MAX_STALL      consecutive stall cycles after which stall_timeout latches
//   CNT_W          width of the performance counters
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   stall_pipeline load-use stall request
//   flush_if_id    flush request for IF/ID
//   flush_id_ex    flush request for ID/EX
//   flush_ex_mem   flush request for EX/MEM
//   halt_req       level request: stop fetching and drain
//   resume         single-cycle pulse: leave HALTED
//   pc_write_en    PC may advance this cycle (combinational)
//   pc_redirect    PC loads the branch target this cycle (combinational)
//   if_id_write_en IF/ID captures this cycle (combinational)
//   id_ex_bubble   ID/EX loads a NOP this cycle (combinational)
//   stage_valid    registered valid bits {wb, mem, ex, id}
//   halted         registered, 1 while in HALTED
//   stall_timeout  sticky watchdog flag, cleared only by reset
//   stall_cycles   RUN cycles spent stalling (optional feature)
//   flush_events   cycles carrying a flush in RUN/DRAIN (optional feature)
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int MAX_STALL = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_pipeline,
  input  logic             flush_if_id,
  input  logic             flush_id_ex,
  input  logic             flush_ex_mem,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_write_en,
  output logic             pc_redirect,
  output logic             if_id_write_en,
  output logic             id_ex_bubble,
  output logic [3:0]       stage_valid,
  output logic             halted,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int SC_W = $clog2(MAX_STALL + 1);
  localparam logic [SC_W-1:0] STALL_LIMIT = SC_W'(MAX_STALL);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            timeout_q, timeout_d;
  logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;

  logic any_flush;
  logic stall_eff;

  // A flush discards the stalling instruction, so it overrides the stall.
  assign any_flush = flush_if_id | flush_id_ex | flush_ex_mem;
  assign stall_eff = stall_pipeline & ~any_flush;

  // Next-state, valid-bit tracking and the combinational enables.
  // Defaults describe the "frozen" pipeline; each state opens what it needs.
  // While reset is asserted the enables are forced to the frozen values so
  // nothing downstream moves before the sequencer is initialised.
  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    pc_write_en    = 1'b0;
    pc_redirect    = 1'b0;
    if_id_write_en = 1'b0;
    id_ex_bubble   = 1'b1;

    case (state_q)
      RUN: begin
        pc_write_en    = ~stall_eff;
        if_id_write_en = ~stall_eff;
        id_ex_bubble   = stall_eff | flush_id_ex;
        pc_redirect    = any_flush;
        // A stall holds the ID instruction and sends a bubble into EX.
        valid_d[0] = ~flush_if_id & (stall_eff ? valid_q[0] : 1'b1);
        valid_d[1] = ~flush_id_ex & ~stall_eff & valid_q[0];
        valid_d[2] = ~flush_ex_mem & valid_q[1];
        valid_d[3] = valid_q[2];
        if (halt_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Nothing new is fetched; in-flight work moves toward WB. Stalls are
        // ignored because the producer is ahead and draining too.
        valid_d[0] = 1'b0;
        valid_d[1] = ~flush_id_ex & valid_q[0];
        valid_d[2] = ~flush_ex_mem & valid_q[1];
        valid_d[3] = valid_q[2];
        if (valid_d == 4'b0000) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        valid_d = 4'b0000;
        if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        valid_d = 4'b0000;
      end
    endcase

    if (!rst_n) begin
      pc_write_en    = 1'b0;
      pc_redirect    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
    end
  end

  // Watchdog: counts consecutive effective stalls in RUN, saturating at the
  // limit. The timeout flag is sticky and only observes, it never blocks.
  always_comb begin
    stall_cnt_d = '0;
    if ((state_q == RUN) && stall_eff) begin
      stall_cnt_d = (stall_cnt_q == STALL_LIMIT) ? stall_cnt_q
                                                 : stall_cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (stall_cnt_d == STALL_LIMIT);
    halted_d  = (state_d == HALTED);
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      valid_q     <= 4'b0000;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stage_valid   = valid_q;
  assign halted        = halted_q;
  assign stall_timeout = timeout_q;

`ifdef PIPELINE_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_perf_q, stall_perf_d;
  logic [CNT_W-1:0] flush_perf_q, flush_perf_d;

  // Saturating event counters; they stop at all-ones rather than wrapping
  // so a long run never reports a deceptively small number.
  always_comb begin
    stall_perf_d = stall_perf_q;
    flush_perf_d = flush_perf_q;
    if ((state_q == RUN) && stall_eff && (stall_perf_q != '1)) begin
      stall_perf_d = stall_perf_q + 1'b1;
    end
    if (((state_q == RUN) || (state_q == DRAIN)) && any_flush &&
        (flush_perf_q != '1)) begin
      flush_perf_d = flush_perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_perf_q <= '0;
      flush_perf_q <= '0;
    end else begin
      stall_perf_q <= stall_perf_d;
      flush_perf_q <= flush_perf_d;
    end
  end

  assign stall_cycles = stall_perf_q;
  assign flush_events = flush_perf_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Self-checking bench for pipeline_ctrl. A table of per-cycle vectors holds
// the inputs, the expected combinational enables and the expected registered
// state after the edge; registered expectations travel through a queue from
// the drive point to the post-edge compare. Hand-written sequences cover the
// drain-with-stall, resume-while-halting and watchdog corner cases.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall_pipeline;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        halt_req;
  logic        resume;
  logic        pc_write_en;
  logic        pc_redirect;
  logic        if_id_write_en;
  logic        id_ex_bubble;
  logic [3:0]  stage_valid;
  logic        halted;
  logic        stall_timeout;
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;

  int compareCount  = 0;
  int mismatchCount = 0;

  pipeline_ctrl #(.MAX_STALL(8), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_pipeline (stall_pipeline),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .flush_ex_mem   (flush_ex_mem),
    .halt_req       (halt_req),
    .resume         (resume),
    .pc_write_en    (pc_write_en),
    .pc_redirect    (pc_redirect),
    .if_id_write_en (if_id_write_en),
    .id_ex_bubble   (id_ex_bubble),
    .stage_valid    (stage_valid),
    .halted         (halted),
    .stall_timeout  (stall_timeout),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       stall;
    logic       fif;
    logic       fie;
    logic       fem;
    logic       halt;
    logic       res;
    logic       expPc;
    logic       expRedir;
    logic       expIfId;
    logic       expBubble;
    logic [3:0] expValid;
    logic       expHalted;
    logic       expTimeout;
  } vec_t;

  typedef struct {
    logic [3:0] valid;
    logic       halted;
    logic       timeout;
  } regExp_t;

  vec_t    vecs[$];
  regExp_t scoreboard[$];

  // Compare helper: counts every comparison and reports mismatches.
  task automatic checkEq(input string name, input int actual, input int expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic addVec(input logic rst, input logic stall, input logic fif,
                        input logic fie, input logic fem, input logic halt,
                        input logic res, input logic ePc, input logic eRd,
                        input logic eIf, input logic eBb, input logic [3:0] eV,
                        input logic eH, input logic eT);
    vec_t v;
    v = '{rst, stall, fif, fie, fem, halt, res, ePc, eRd, eIf, eBb, eV, eH, eT};
    vecs.push_back(v);
  endtask

  task automatic driveInputs(input logic rst, input logic stall, input logic fif,
                             input logic fie, input logic fem, input logic halt,
                             input logic res);
    @(negedge clk);
    rst_n          = rst;
    stall_pipeline = stall;
    flush_if_id    = fif;
    flush_id_ex    = fie;
    flush_ex_mem   = fem;
    halt_req       = halt;
    resume         = res;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one vector, checks the combinational enables mid-cycle and queues
  // the registered expectations for the post-edge compare.
  task automatic applyStimulus(input vec_t v, input int idx);
    regExp_t e;
    driveInputs(v.rst, v.stall, v.fif, v.fie, v.fem, v.halt, v.res);
    checkEq($sformatf("v%0d pc_write_en", idx), int'(pc_write_en), int'(v.expPc));
    checkEq($sformatf("v%0d pc_redirect", idx), int'(pc_redirect), int'(v.expRedir));
    checkEq($sformatf("v%0d if_id_write_en", idx), int'(if_id_write_en), int'(v.expIfId));
    checkEq($sformatf("v%0d id_ex_bubble", idx), int'(id_ex_bubble), int'(v.expBubble));
    e.valid   = v.expValid;
    e.halted  = v.expHalted;
    e.timeout = v.expTimeout;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input int idx);
    regExp_t e;
    tick();
    if (scoreboard.size() == 0) begin
      compareCount++;
      mismatchCount++;
      $display("[TB] FAIL v%0d scoreboard: got empty queue, expected an entry", idx);
    end else begin
      e = scoreboard.pop_front();
      checkEq($sformatf("v%0d stage_valid", idx), int'(stage_valid), int'(e.valid));
      checkEq($sformatf("v%0d halted", idx), int'(halted), int'(e.halted));
      checkEq($sformatf("v%0d stall_timeout", idx), int'(stall_timeout), int'(e.timeout));
`ifndef PIPELINE_PERF_COUNTERS_EN
      checkEq($sformatf("v%0d stall_cycles", idx), int'(stall_cycles), 0);
      checkEq($sformatf("v%0d flush_events", idx), int'(flush_events), 0);
`endif
    end
  endtask

  // Holds halt_req until halted rises, bounded so a broken drain cannot hang.
  task automatic waitHalted(input string name);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 20) begin
      driveInputs(1, 0, 0, 0, 0, 1, 0);
      tick();
      n++;
    end
    checkEq(name, int'(halted), 1);
  endtask

  initial begin
    rst_n = 1'b0; stall_pipeline = 1'b0; flush_if_id = 1'b0;
    flush_id_ex = 1'b0; flush_ex_mem = 1'b0; halt_req = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);

    //      rst st fif fie fem hlt res | pc rd if bb  valid   h  to
    addVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 4'b0000, 0, 0);
    // fill after reset release
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b0001, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b0011, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b0111, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b1111, 0, 0);
    // single stall: bubble enters EX and travels to WB
    addVec(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 4'b1101, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b1011, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b0111, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b1111, 0, 0);
    // stall together with IF/ID + ID/EX flush: flush wins
    addVec(1, 1, 1, 1, 0, 0, 0,  1, 1, 1, 1, 4'b1100, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b1001, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b0011, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b0111, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b1111, 0, 0);
    // EX/MEM flush alone
    addVec(1, 0, 0, 0, 1, 0, 0,  1, 1, 1, 0, 4'b1011, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b0111, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b1111, 0, 0);
    // halt: one RUN cycle, then drain to HALTED
    addVec(1, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 4'b1111, 0, 0);
    addVec(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 4'b1110, 0, 0);
    addVec(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 4'b1100, 0, 0);
    addVec(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 4'b1000, 0, 0);
    addVec(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 4'b0000, 1, 0);
    addVec(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 4'b0000, 1, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 4'b0000, 1, 0);
    // resume with halt_req low
    addVec(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 4'b0000, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b0001, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b0011, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b0111, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b1111, 0, 0);
    // reset in the middle of a drain
    addVec(1, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 4'b1111, 0, 0);
    addVec(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 4'b1110, 0, 0);
    addVec(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 4'b1100, 0, 0);
    addVec(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 4'b0000, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 4'b0001, 0, 0);
    // resume outside HALTED has no effect
    addVec(1, 0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 4'b0011, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
      checkOutput(i);
    end

    // Drain ignores stall while an ID/EX flush still clears its stage.
    for (int i = 0; i < 2; i++) begin
      driveInputs(1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    checkEq("refill", int'(stage_valid), 4'b1111);
    driveInputs(1, 0, 0, 0, 0, 1, 0);
    tick();
    driveInputs(1, 1, 0, 1, 0, 1, 0);
    checkEq("drain stall pc_write_en", int'(pc_write_en), 0);
    checkEq("drain flush pc_redirect", int'(pc_redirect), 0);
    checkEq("drain id_ex_bubble", int'(id_ex_bubble), 1);
    tick();
    checkEq("drain flush valid", int'(stage_valid), 4'b1100);
    waitHalted("drain reaches halted");

    // Resume while halt_req is still high: one RUN cycle, then drain again.
    driveInputs(1, 0, 0, 0, 0, 1, 1);
    tick();
    checkEq("resume-halt halted", int'(halted), 0);
    driveInputs(1, 0, 0, 0, 0, 1, 0);
    checkEq("resume-halt run pc_write_en", int'(pc_write_en), 1);
    tick();
    checkEq("resume-halt valid", int'(stage_valid), 4'b0001);
    driveInputs(1, 0, 0, 0, 0, 1, 0);
    checkEq("resume-halt drain pc_write_en", int'(pc_write_en), 0);
    tick();
    checkEq("resume-halt drain valid", int'(stage_valid), 4'b0010);
    waitHalted("resume-halt re-halts");
    driveInputs(1, 0, 0, 0, 0, 0, 1);
    tick();
    checkEq("resume run", int'(halted), 0);

    // Broken stall runs must not trip the watchdog.
    for (int k = 0; k < 5; k++) begin
      driveInputs(1, 1, 0, 0, 0, 0, 0);
      tick();
    end
    driveInputs(1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      driveInputs(1, 1, 0, 0, 0, 0, 0);
      tick();
    end
    checkEq("watchdog clears between stalls", int'(stall_timeout), 0);
    driveInputs(1, 0, 0, 0, 0, 0, 0);
    tick();

    // Ten consecutive stalls: timeout rises on the 8th and stays sticky.
    for (int k = 1; k <= 10; k++) begin
      driveInputs(1, 1, 0, 0, 0, 0, 0);
      tick();
      checkEq($sformatf("watchdog stall %0d", k), int'(stall_timeout), (k >= 8) ? 1 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      driveInputs(1, 0, 0, 0, 0, 0, 0);
      tick();
      checkEq("watchdog sticky", int'(stall_timeout), 1);
    end
    driveInputs(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkEq("watchdog reset", int'(stall_timeout), 0);
    checkEq("reset valid", int'(stage_valid), 4'b0000);
    driveInputs(1, 0, 0, 0, 0, 0, 0);
    tick();
    checkEq("post-reset valid", int'(stage_valid), 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion, expected finish before limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount + 1);
    $fatal(1, "[TB] time limit reached");
  end

endmodule
